// File: rtl/tiny16_io_pkg.sv
// Shared I/O word layout for tiny16 port blocks (keyboard, display, CPU IN/OUT decode).
// The helper builds the 16-bit word the CPU sees on an input-port read.
package tiny16_io_pkg;

  localparam int IO_VALID_BIT = 8;
  localparam int IO_OVF_BIT   = 15;
  localparam int IO_DATA_W    = 8;
  localparam int IO_WORD_W    = 16;

  function automatic logic [IO_WORD_W-1:0] io_word(input logic                 ovf,
                                                   input logic                 valid,
                                                   input logic [IO_DATA_W-1:0] data);
    logic [IO_WORD_W-1:0] w;
    w                 = '0;
    w[IO_OVF_BIT]     = ovf;
    w[IO_VALID_BIT]   = valid;
    w[IO_DATA_W-1:0]  = data;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with power-of-two depth and natural pointer wrap.
// A pop on a full FIFO frees the slot a same-cycle push needs; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; stale entries are never observable because
  // count gates every read, and leaving it out keeps the array in plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keyboard.sv
// tiny16 keyboard input port: buffers host bytes and returns one tagged word per CPU read.
// Holds the accept/drop decision, the sticky overflow flag and the CPU-facing out register.
module keyboard
  import tiny16_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [IO_DATA_W-1:0] key_data,
  output logic                 key_ready,
  input  logic                 rd_en,
  output logic [IO_WORD_W-1:0] out,
  output logic                 avail,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 fifo_push;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic [IO_DATA_W-1:0] head;

  // A full FIFO still takes the byte when the CPU reads in the same cycle.
  assign fifo_push = key_valid && (!full || rd_en);
  assign drop      = key_valid && !fifo_push;

  assign avail     = (count != '0);
  assign key_ready = (count < CNT_W'(DEPTH));

  sync_fifo #(
    .WIDTH (IO_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (key_data),
    .pop   (rd_en),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (rd_en) begin
      // The word reports the flag as it stood before this read; a drop in the
      // same cycle re-arms it for the next read.
      out      <= empty ? io_word(overflow, 1'b0, '0) : io_word(overflow, 1'b1, head);
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keyboard.sv
// Self-checking bench for keyboard: a queue model predicts each read word into a scoreboard,
// and the DUT's word is compared against it one cycle after rd_en.
module tb_keyboard;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_ready;
  logic        rd_en = 1'b0;
  logic [15:0] out;
  logic        avail;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  model_q[$];
  logic [15:0] sb_q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_out = 16'h0000;

  keyboard #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .rd_en     (rd_en),
    .out       (out),
    .avail     (avail),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; model updated at drive time, DUT compared #1 after the edge.
  task automatic cycle(input logic kv, input logic [7:0] kd, input logic rd);
    int   sz;
    logic rd_hit;
    logic accept;
    logic drop;
    key_valid = kv;
    key_data  = kd;
    rd_en     = rd;
    sz     = model_q.size();
    rd_hit = rd && (sz != 0);
    accept = kv && ((sz < DEPTH) || rd_hit);
    drop   = kv && !accept;
    if (rd) begin
      if (sz == 0) sb_q.push_back({m_ovf, 15'h0000});
      else         sb_q.push_back({m_ovf, 6'b0, 1'b1, model_q[0]});
      if (sz != 0) void'(model_q.pop_front());
    end
    if (accept) model_q.push_back(kd);
    if (rd)        m_ovf = drop;
    else if (drop) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    rd_en     = 1'b0;
    if (rd) begin
      if (sb_q.size() == 0) check("sb_empty", 16'd1, 16'd0);
      else begin
        m_out = sb_q.pop_front();
        check("rd_word", out, m_out);
      end
    end else begin
      check("out_hold", out, m_out);
    end
    check("avail", 16'(avail), 16'(model_q.size() != 0));
    check("key_ready", 16'(key_ready), 16'(model_q.size() < DEPTH));
    check("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  task automatic model_reset();
    model_q.delete();
    sb_q.delete();
    m_ovf = 1'b0;
    m_out = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 16'h0000);
    check("rst_avail", 16'(avail), 16'h0000);
    check("rst_key_ready", 16'(key_ready), 16'h0001);
    check("rst_overflow", 16'(overflow), 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 8'h00, 1'b1);
    check("empty_read", out, 16'h0000);

    // Single byte round trip
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_read", out, 16'h0141);
    check("single_avail", 16'(avail), 16'h0000);
    cycle(1'b0, 8'h00, 1'b1);
    check("second_read", out, 16'h0000);

    // Overflow on fifth byte
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0);
    check("ovf_set", 16'(overflow), 16'h0001);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovf_read0", out, 16'h8131);
    check("ovf_cleared", 16'(overflow), 16'h0000);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovf_read1", out, 16'h0132);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovf_read2", out, 16'h0133);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovf_read3", out, 16'h0134);

    // Full FIFO with simultaneous push and read
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h61 + 8'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    check("full_rw_word", out, 16'h0161);
    check("full_rw_ready", 16'(key_ready), 16'h0000);
    check("full_rw_ovf", 16'(overflow), 16'h0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    check("full_rw_tail", out, 16'h0155);

    // Empty FIFO with simultaneous push and read: no bypass
    cycle(1'b1, 8'h7A, 1'b1);
    check("nobypass_first", out, 16'h0000);
    cycle(1'b0, 8'h00, 1'b1);
    check("nobypass_second", out, 16'h017A);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      cycle(1'(($urandom_range(0, 99) < 60)), 8'($urandom), 1'(($urandom_range(0, 99) < 45)));

    // Drain, then build the mid-burst reset scenario
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0);
    check("pre_rst_out", out, 16'h0142);
    key_valid = 1'b1;
    key_data  = 8'h53;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 16'h0000);
    check("async_rst_avail", 16'(avail), 16'h0000);
    check("async_rst_ready", 16'(key_ready), 16'h0001);
    check("async_rst_ovf", 16'(overflow), 16'h0000);
    key_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_read", out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keyboard.md
# keyboard

Input-port block for tiny16: the receive-side counterpart of the display output port. An external byte source (host terminal model or testbench) pushes 8-bit characters with a one-cycle strobe. The block buffers them in a small FIFO and hands them to the CPU one at a time when the CPU issues an input-port read pulse. Each returned 16-bit word carries a valid flag and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  host strobe; one byte is offered in each cycle it is high.
- key_data  in  8  byte offered with key_valid.
- key_ready  out  1  high when FIFO count < DEPTH; advisory only, the host may ignore it.
- rd_en  in  1  CPU input-port read pulse from instruction decode.
- out  out  16  read data register presented to the CPU datapath.
- avail  out  1  high when FIFO count ≠ 0; CPU polls this.
- overflow  out  1  sticky; set when a byte was dropped.

## Operation
- Storage is a circular buffer of DEPTH × 8 bits, with write pointer, read pointer (log2(DEPTH) bits, natural wrap) and count ($clog2(DEPTH)+1 bits).
- Write rule: on key_valid, the byte is accepted if count < DEPTH, or if count == DEPTH and rd_en is high in the same cycle (the read frees a slot).
- Otherwise the byte is dropped, overflow ← 1, and the pointers are unchanged.
- Read with count ≠ 0 on rd_en:
  - out ← {overflow, 6'b0, 1'b1, head byte}.
  - Read pointer advances.
  - overflow ← 0, unless a drop occurs in that same cycle, in which case it stays 1.
- Read with count == 0 on rd_en:
  - out ← {overflow, 15'h0000}, i.e. the valid bit out[8] is 0.
  - overflow is cleared under the same rule as a normal read.
- There is no bypass. A write and a read in the same cycle on an empty FIFO stores the byte, and the read returns the empty word.
- count update: +1 on accepted write without read; −1 on a successful read without write; unchanged when both or neither occur.
- out holds its value between reads. It does not self-clear, unlike the display trigger path.
- Reset (rst_n low, any time including mid-transfer):
  - out = 16'h0000, overflow = 0, pointers = 0, count = 0.
  - Outputs at reset: avail = 0, key_ready = 1.
  - FIFO contents are don't-care.

## Timing
- rd_en sampled at edge N; out is valid after edge N and stable until the next rd_en edge. CPU read latency is 1 cycle.
- key_valid sampled at edge N; avail rises after edge N when the FIFO was empty.
- Minimum write-to-read latency is 1 cycle: a byte written at edge N is readable by an rd_en sampled at edge N+1.
- avail and key_ready are decoded directly from the count register. There is no combinational path from inputs to outputs.
- Throughput: one write and one read per cycle sustained; the full FIFO with simultaneous read and write stays full with no drop.
- Reset assertion takes effect asynchronously. Deassertion is assumed synchronous to clk (handled by the top-level reset synchronizer).

## Structure
- Shared package tiny16_io_pkg holds:
  - IO_VALID_BIT = 8, IO_OVF_BIT = 15, IO_DATA_W = 8, IO_WORD_W = 16.
  - These are shared with display and the CPU IN/OUT decode.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/count). It is reusable by a later UART block.
- keyboard contains the accept/drop logic, the overflow flag and the out register.

## Test plan
- Reset then idle: out = 16'h0000, avail = 0, key_ready = 1, overflow = 0; rd_en on empty → out = 16'h0000.
- Push 8'h41 then rd_en next cycle → out = 16'h0141, avail falls to 0; a second rd_en → out = 16'h0000.
- DEPTH = 4, push 8'h31..8'h35 back-to-back → the fifth byte is dropped, overflow = 1. Four reads return 16'h8131 (overflow is reported on the first read and cleared by it), then 16'h0132, 16'h0133, 16'h0134.
- Full FIFO with key_valid = 1 (8'h55) and rd_en in the same cycle → head is returned, 8'h55 is accepted, count stays 4, overflow stays 0.
- Empty FIFO with simultaneous push 8'h7A and rd_en → out = 16'h0000; the next rd_en → out = 16'h017A.
- Assert rst_n low mid-burst (count = 3, out = 16'h0142) → all outputs return to their reset values immediately, before the next clk edge; after release, rd_en → 16'h0000.
